// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: port-index type and one-hot decode shared by the arbiter slice.
package sram_arbiter_pkg;
  localparam int MAX_PORTS = 16;
  typedef logic [$clog2(MAX_PORTS)-1:0] port_idx_t;
  function automatic port_idx_t onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
    port_idx_t idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) if (oh[i]) idx = idx | port_idx_t'(i);
    return idx;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter; the port after the last grant has highest priority.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);
  logic [N-1:0] ptr_d, ptr_q;
  logic [2*N-1:0] dbl_req, dbl_gnt, rot;
  always_comb begin
    dbl_req = {req, req};
    // Borrow from the priority bit finds the first request at or after it, wrapping through the upper copy.
    dbl_gnt = dbl_req & ~(dbl_req - {{N{1'b0}}, ptr_q});
    grant = reset_n ? (dbl_gnt[N-1:0] | dbl_gnt[2*N-1:N]) : '0;
    rot = {grant, grant} << 1;
    ptr_d = (en && |grant) ? rot[2*N-1:N] : ptr_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr_q <= N'(1);
    else ptr_q <= ptr_d;
endmodule

// File: rtl/sram_1r1w.sv
// sram_1r1w: one-read one-write SRAM, registered read, write data forwarded on same-address collision.
module sram_1r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE = 1024,
  localparam int ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);
  logic [DATA_WIDTH-1:0] mem [SIZE];
  logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  always_comb
    rd_data_d = !rd_en ? rd_data_q : (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rd_data_q <= '0;
    else rd_data_q <= rd_data_d;
  assign rd_data = rd_data_q;
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin sharing of one sram_1r1w between NUM_PORTS read and write requesters.
// Define SRAM_ARBITER_PERF_EN to add the saturating rd_conflict_count output.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SIZE = 1024,
  localparam int ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
`ifdef SRAM_ARBITER_PERF_EN
  output logic [31:0]                          rd_conflict_count,
`endif
  input  logic [NUM_PORTS-1:0]                 rd_req,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_PORTS-1:0]                 rd_grant,
  output logic [NUM_PORTS-1:0]                 rd_resp_valid,
  output logic [DATA_WIDTH-1:0]                rd_resp_data,
  input  logic [NUM_PORTS-1:0]                 wr_req,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wr_data,
  output logic [NUM_PORTS-1:0]                 wr_grant
);
  localparam int IDX_W = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [NUM_PORTS-1:0] rd_valid_d, rd_valid_q;
  logic [ADDR_WIDTH-1:0] sram_rd_addr, sram_wr_addr;
  logic [DATA_WIDTH-1:0] sram_wr_data;
  logic sram_rd_en, sram_wr_en;
  rr_arbiter #(.N(NUM_PORTS)) u_rd_arb (
    .clk(clk), .reset_n(reset_n), .req(rd_req), .en(1'b1), .grant(rd_grant)
  );
  rr_arbiter #(.N(NUM_PORTS)) u_wr_arb (
    .clk(clk), .reset_n(reset_n), .req(wr_req), .en(1'b1), .grant(wr_grant)
  );
  always_comb begin
    rd_idx = IDX_W'(onehot_to_idx(MAX_PORTS'(rd_grant)));
    wr_idx = IDX_W'(onehot_to_idx(MAX_PORTS'(wr_grant)));
    sram_rd_en = |rd_grant;
    sram_wr_en = |wr_grant;
    sram_rd_addr = rd_addr[rd_idx];
    sram_wr_addr = wr_addr[wr_idx];
    sram_wr_data = wr_data[wr_idx];
    rd_valid_d = rd_grant;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rd_valid_q <= '0;
    else rd_valid_q <= rd_valid_d;
  assign rd_resp_valid = rd_valid_q;
  sram_1r1w #(.DATA_WIDTH(DATA_WIDTH), .SIZE(SIZE)) u_sram (
    .clk(clk), .reset_n(reset_n),
    .rd_en(sram_rd_en), .rd_addr(sram_rd_addr), .rd_data(rd_resp_data),
    .wr_en(sram_wr_en), .wr_addr(sram_wr_addr), .wr_data(sram_wr_data)
  );
`ifdef SRAM_ARBITER_PERF_EN
  logic [31:0] conflict_d, conflict_q;
  always_comb
    conflict_d = ((rd_req & (rd_req - 1'b1)) != '0 && conflict_q != '1) ? conflict_q + 32'd1 : conflict_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) conflict_q <= '0;
    else conflict_q <= conflict_d;
  assign rd_conflict_count = conflict_q;
`endif
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vectors for sram_arbiter with hand-computed expectations.
module tb_sram_arbiter;
  localparam int NP = 4, DW = 32, SZ = 1024, AW = 10;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NP-1:0] rd_req, wr_req, rd_grant, wr_grant, rd_resp_valid;
  logic [NP-1:0][AW-1:0] rd_addr, wr_addr;
  logic [NP-1:0][DW-1:0] wr_data;
  logic [DW-1:0] rd_resp_data;
`ifdef SRAM_ARBITER_PERF_EN
  logic [31:0] rd_conflict_count;
`endif
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  sram_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .SIZE(SZ)) dut (
    .clk(clk), .reset_n(reset_n),
`ifdef SRAM_ARBITER_PERF_EN
    .rd_conflict_count(rd_conflict_count),
`endif
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_grant(wr_grant)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic settle;
    #1;
  endtask
  task automatic do_reset;
    reset_n = 1'b0;
    step;
    step;
    reset_n = 1'b1;
  endtask
  initial begin
    rd_req = '0;
    wr_req = '0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    reset_n = 1'b0;
    rd_req = '1;
    wr_req = '1;
    step;
    check("rst_rd_gnt", 32'(rd_grant), 32'h0);
    check("rst_wr_gnt", 32'(wr_grant), 32'h0);
    check("rst_valid", 32'(rd_resp_valid), 32'h0);
    check("rst_data", rd_resp_data, 32'h0);
    rd_req = '0;
    wr_req = '0;
    step;
    reset_n = 1'b1;
    // write port1 addr5, then read port2 addr5
    wr_addr[1] = 10'd5;
    wr_data[1] = 32'hDEADBEEF;
    wr_req = 4'b0010;
    settle;
    check("wr1_gnt", 32'(wr_grant), 32'b0010);
    check("idle_rd_gnt", 32'(rd_grant), 32'h0);
    step;
    wr_req = '0;
    rd_addr[2] = 10'd5;
    rd_req = 4'b0100;
    settle;
    check("rd2_gnt", 32'(rd_grant), 32'b0100);
    check("idle_wr_gnt", 32'(wr_grant), 32'h0);
    step;
    rd_req = '0;
    settle;
    check("rd2_valid", 32'(rd_resp_valid), 32'b0100);
    check("rd2_data", rd_resp_data, 32'hDEADBEEF);
    step;
    check("rd2_valid_once", 32'(rd_resp_valid), 32'h0);
    // preload addr 0..3 via a single continuously requesting port
    wr_req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      wr_addr[0] = AW'(i);
      wr_data[0] = 32'hA000_0000 + 32'(i);
      settle;
      check("wr_cont_gnt", 32'(wr_grant), 32'b0001);
      step;
    end
    wr_req = '0;
    // all ports read every cycle for 8 cycles after reset
    do_reset;
    for (int p = 0; p < NP; p++) rd_addr[p] = AW'(p);
    for (int k = 0; k <= 8; k++) begin
      rd_req = (k < 8) ? 4'b1111 : 4'b0000;
      settle;
      if (k < 8) check("rr_gnt", 32'(rd_grant), 32'(1) << (k % 4));
      if (k > 0) begin
        check("rr_valid", 32'(rd_resp_valid), 32'(1) << ((k - 1) % 4));
        check("rr_data", rd_resp_data, 32'hA000_0000 + 32'((k - 1) % 4));
      end
      step;
    end
    rd_req = '0;
    // same-cycle write and read of addr 9
    wr_addr[0] = 10'd9;
    wr_data[0] = 32'h0;
    wr_req = 4'b0001;
    step;
    wr_req = '0;
    rd_addr[3] = 10'd9;
    rd_req = 4'b1000;
    step;
    rd_req = '0;
    settle;
    check("a9_old", rd_resp_data, 32'h0);
    wr_data[0] = 32'h12345678;
    wr_req = 4'b0001;
    rd_req = 4'b1000;
    settle;
    check("fwd_wr_gnt", 32'(wr_grant), 32'b0001);
    check("fwd_rd_gnt", 32'(rd_grant), 32'b1000);
    step;
    wr_req = '0;
    rd_req = '0;
    settle;
    check("fwd_valid", 32'(rd_resp_valid), 32'b1000);
    check("fwd_data", rd_resp_data, 32'h12345678);
    rd_addr[2] = 10'd9;
    rd_req = 4'b0100;
    step;
    rd_req = '0;
    settle;
    check("a9_stored", rd_resp_data, 32'h12345678);
    // read granted, then reset drops the response
    rd_addr[1] = 10'd0;
    rd_req = 4'b0010;
    settle;
    check("pre_rst_gnt", 32'(rd_grant), 32'b0010);
    @(posedge clk);
    reset_n = 1'b0;
    rd_req = '0;
    settle;
    check("drop_valid", 32'(rd_resp_valid), 32'h0);
    step;
    check("drop_valid2", 32'(rd_resp_valid), 32'h0);
    reset_n = 1'b1;
    rd_req = 4'b1111;
    wr_req = 4'b1111;
    settle;
    check("post_rst_rd", 32'(rd_grant), 32'b0001);
    check("post_rst_wr", 32'(wr_grant), 32'b0001);
    step;
    rd_req = '0;
    wr_req = '0;
    // sparse requests skip idle ports; idle cycle holds the pointer
    do_reset;
    rd_req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      settle;
      check("skip_gnt", 32'(rd_grant), (k % 2 == 0) ? 32'b0010 : 32'b1000);
      step;
    end
    rd_req = '0;
    step;
    rd_req = 4'b1111;
    settle;
    check("hold_ptr", 32'(rd_grant), 32'b0100);
    step;
    rd_req = '0;
`ifdef SRAM_ARBITER_PERF_EN
    do_reset;
    check("perf_rst", rd_conflict_count, 32'd0);
    rd_req = 4'b1011;
    repeat (3) step;
    rd_req = 4'b0001;
    repeat (2) step;
    rd_req = '0;
    settle;
    check("perf_cnt", rd_conflict_count, 32'd3);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
